// File: rtl/mem_access_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : mem_access_unit                                            |
// | Description : CPU data-memory initiator. Splits one byte/half/word       |
// |               load or store into consecutive single-byte accesses,       |
// |               big-endian (byte at Addr is most significant). Loads are   |
// |               zero- or sign-extended; misaligned requests are aborted    |
// |               before any memory access.                                  |
// | Options     : `define MAU_BOUNDS_CHECK_EN adds a range check against     |
// |               MEM_BYTES and the BoundErr output.                         |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module mem_access_unit #(
  parameter int MEM_BYTES = 512
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        Start,
  input  logic        RW,
  input  logic [1:0]  Size,
  input  logic        Signed,
  input  logic [31:0] Addr,
  input  logic [31:0] DataIn,
  output logic        Busy,
  output logic        Done,
  output logic [31:0] DataOut,
  output logic        AlignErr,
`ifdef MAU_BOUNDS_CHECK_EN
  output logic        BoundErr,
`endif
  output logic        MemEn,
  output logic        MemRW,
  output logic [31:0] MemAddr,
  output logic [7:0]  MemWData,
  input  logic [7:0]  MemRData
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_next;

  logic        r_rw;
  logic [1:0]  r_size;
  logic        r_signed;
  logic [31:0] r_addr;
  logic [1:0]  r_last;      // byte count minus one
  logic [1:0]  r_cnt;
  logic [31:0] r_wdata;     // store data left-justified, next byte in [31:24]
  logic [23:0] r_acc;       // load bytes gathered so far, MSB first
  logic        r_alignerr;

  logic [1:0]  w_nbytes_m1;
  logic        w_misalign;
  logic        w_abort;
  logic [31:0] w_wdata_just;
  logic [31:0] w_acc_next;
  logic [31:0] w_load_result;

`ifdef MAU_BOUNDS_CHECK_EN
  logic        r_bounderr;
  logic        w_oob;
  // Last byte of the request must lie inside the attached memory.
  assign w_oob   = (({1'b0, Addr} + {31'd0, w_nbytes_m1}) >= 33'(MEM_BYTES));
  assign w_abort = w_misalign | w_oob;
`else
  // Parameter is only consumed by the optional range check.
  localparam int c_mem_bytes_unused = MEM_BYTES;
  assign w_abort = w_misalign;
`endif

  // Decode the incoming request: byte count, alignment and store-data justification.
  always_comb begin
    w_nbytes_m1  = 2'd3;
    w_misalign   = 1'b0;
    w_wdata_just = DataIn;
    case (Size)
      2'b00: begin
        w_nbytes_m1  = 2'd0;
        w_wdata_just = {DataIn[7:0], 24'd0};
      end
      2'b01: begin
        w_nbytes_m1  = 2'd1;
        w_misalign   = Addr[0];
        w_wdata_just = {DataIn[15:0], 16'd0};
      end
      2'b10: begin
        w_nbytes_m1  = 2'd3;
        w_misalign   = |Addr[1:0];
      end
      default: begin
        w_nbytes_m1  = 2'd3;
        w_misalign   = 1'b1;
      end
    endcase
  end

  // Accumulator including the byte arriving this cycle, then extended by size.
  assign w_acc_next = {r_acc, MemRData};

  always_comb begin
    case (r_size)
      2'b00:   w_load_result = {{24{r_signed & w_acc_next[7]}},  w_acc_next[7:0]};
      2'b01:   w_load_result = {{16{r_signed & w_acc_next[15]}}, w_acc_next[15:0]};
      default: w_load_result = w_acc_next;
    endcase
  end

  // State register.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // Request capture, byte sequencing and load result update.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      r_rw       <= 1'b0;
      r_size     <= 2'd0;
      r_signed   <= 1'b0;
      r_addr     <= 32'd0;
      r_last     <= 2'd0;
      r_cnt      <= 2'd0;
      r_wdata    <= 32'd0;
      r_acc      <= 24'd0;
      r_alignerr <= 1'b0;
      DataOut    <= 32'd0;
`ifdef MAU_BOUNDS_CHECK_EN
      r_bounderr <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (Start) begin
            r_rw       <= RW;
            r_size     <= Size;
            r_signed   <= Signed;
            r_addr     <= Addr;
            r_last     <= w_nbytes_m1;
            r_cnt      <= 2'd0;
            r_wdata    <= w_wdata_just;
            r_acc      <= 24'd0;
            r_alignerr <= w_misalign;
`ifdef MAU_BOUNDS_CHECK_EN
            r_bounderr <= w_oob;
`endif
          end
        end
        S_ACCESS: begin
          r_cnt   <= r_cnt + 2'd1;
          r_wdata <= {r_wdata[23:0], 8'd0};
          if (!r_rw) begin
            r_acc <= w_acc_next[23:0];
            // Final byte lands now so DataOut is already valid in the Done cycle.
            if (r_cnt == r_last) DataOut <= w_load_result;
          end
        end
        default: ;
      endcase
    end
  end

  // Next-state and output decode.
  always_comb begin
    w_state_next = r_state;
    Busy         = 1'b0;
    Done         = 1'b0;
    AlignErr     = 1'b0;
    MemEn        = 1'b0;
    MemRW        = 1'b0;
    MemAddr      = 32'd0;
    MemWData     = 8'd0;
`ifdef MAU_BOUNDS_CHECK_EN
    BoundErr     = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (Start) w_state_next = w_abort ? S_FINISH : S_ACCESS;
      end
      S_ACCESS: begin
        Busy     = 1'b1;
        MemEn    = 1'b1;
        MemRW    = r_rw;
        MemAddr  = r_addr + {30'd0, r_cnt};
        MemWData = r_rw ? r_wdata[31:24] : 8'd0;
        if (r_cnt == r_last) w_state_next = S_FINISH;
      end
      S_FINISH: begin
        Busy         = 1'b1;
        Done         = 1'b1;
        AlignErr     = r_alignerr;
`ifdef MAU_BOUNDS_CHECK_EN
        BoundErr     = r_bounderr;
`endif
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_mem_access_unit                                         |
// | Description : Scoreboard bench for mem_access_unit with a byte memory    |
// |               model; directed requests with hand-computed results.       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_mem_access_unit;

  logic        CLK;
  logic        Reset;
  logic        Start;
  logic        RW;
  logic [1:0]  Size;
  logic        Signed;
  logic [31:0] Addr;
  logic [31:0] DataIn;
  logic        Busy;
  logic        Done;
  logic [31:0] DataOut;
  logic        AlignErr;
  logic        MemEn;
  logic        MemRW;
  logic [31:0] MemAddr;
  logic [7:0]  MemWData;
  logic [7:0]  MemRData;

  mem_access_unit #(.MEM_BYTES(512)) dut (
    .CLK(CLK), .Reset(Reset), .Start(Start), .RW(RW), .Size(Size),
    .Signed(Signed), .Addr(Addr), .DataIn(DataIn), .Busy(Busy), .Done(Done),
    .DataOut(DataOut), .AlignErr(AlignErr), .MemEn(MemEn), .MemRW(MemRW),
    .MemAddr(MemAddr), .MemWData(MemWData), .MemRData(MemRData)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Byte memory: combinational read, write on the rising edge.
  logic [7:0] mem [0:511];
  assign MemRData = mem[MemAddr[8:0]];
  always @(posedge CLK) if (MemEn && MemRW) mem[MemAddr[8:0]] <= MemWData;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct { logic rw; logic [31:0] addr; logic [7:0] wd; } acc_t;
  typedef struct { int cyc; logic al; logic [31:0] dout; } rsp_t;
  acc_t acc_q[$];
  rsp_t rsp_q[$];

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_dout = 32'd0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic bad(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: actual=event required=none", nm);
  endtask

  // Monitor: every memory access and every Done is matched against the queues.
  always @(negedge CLK) begin
    if (Reset) begin
      if (MemEn) begin
        if (acc_q.size() == 0) bad("unexpected_mem_access");
        else begin
          acc_t a;
          a = acc_q.pop_front();
          chk("mem_rw", 32'(MemRW), 32'(a.rw));
          chk("mem_addr", MemAddr, a.addr);
          if (a.rw) chk("mem_wdata", 32'(MemWData), 32'(a.wd));
        end
      end
      if (Done) begin
        if (rsp_q.size() == 0) bad("unexpected_done");
        else begin
          rsp_t r;
          r = rsp_q.pop_front();
          chk("done_latency", 32'(cyc), 32'(r.cyc));
          chk("align_err", 32'(AlignErr), 32'(r.al));
          chk("data_out", DataOut, r.dout);
        end
      end
    end
  end

  // Issue one request; n = byte count (0 for aborted), exp_d = DataOut expected at Done.
  task automatic req(input logic rw, input logic [1:0] sz, input logic sgn,
                     input logic [31:0] a, input logic [31:0] din,
                     input logic exp_al, input logic [31:0] exp_d,
                     input int n, input bit poke);
    bit got;
    rsp_t r;
    @(negedge CLK);
    RW = rw; Size = sz; Signed = sgn; Addr = a; DataIn = din; Start = 1'b1;
    for (int k = 0; k < n; k++) begin
      acc_t e;
      e.rw = rw;
      e.addr = a + 32'(k);
      e.wd = 8'(din >> (8 * (n - 1 - k)));
      acc_q.push_back(e);
    end
    r.cyc = cyc + 1 + n; r.al = exp_al; r.dout = exp_d;
    rsp_q.push_back(r);
    exp_dout = exp_d;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      Start = 1'b0;
      if (Done) begin got = 1'b1; break; end
    end
    if (!got) begin
      bad("done_timeout");
      rsp_q.delete();
      acc_q.delete();
    end
    if (poke) begin
      // A Start presented during Done must be ignored.
      Start = 1'b1; RW = 1'b1; Size = 2'b00; Addr = 32'h40; DataIn = 32'h5A;
      @(negedge CLK);
      Start = 1'b0;
    end
    @(negedge CLK);
    @(negedge CLK);
    chk("dout_hold", DataOut, exp_dout);
    chk("idle_busy", 32'(Busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 8'h00;
    mem[2] = 8'hF0;
    mem[3] = 8'h01;
    Reset = 1'b0; Start = 1'b0; RW = 1'b0; Size = 2'b00; Signed = 1'b0;
    Addr = 32'd0; DataIn = 32'd0;
    repeat (3) @(negedge CLK);
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_done", 32'(Done), 32'd0);
    chk("rst_alignerr", 32'(AlignErr), 32'd0);
    chk("rst_memen", 32'(MemEn), 32'd0);
    chk("rst_memrw", 32'(MemRW), 32'd0);
    chk("rst_memaddr", MemAddr, 32'd0);
    chk("rst_memwdata", 32'(MemWData), 32'd0);
    chk("rst_dataout", DataOut, 32'd0);
    Reset = 1'b1;

    // Word store, word load of the same bytes.
    req(1'b1, 2'b10, 1'b0, 32'h8, 32'h11223344, 1'b0, 32'h00000000, 4, 1'b0);
    req(1'b0, 2'b10, 1'b0, 32'h8, 32'h0,        1'b0, 32'h11223344, 4, 1'b0);
    // Half loads of 0xF0,0x01 signed and unsigned.
    req(1'b0, 2'b01, 1'b1, 32'h2, 32'h0,        1'b0, 32'hFFFFF001, 2, 1'b0);
    req(1'b0, 2'b01, 1'b0, 32'h2, 32'h0,        1'b0, 32'h0000F001, 2, 1'b0);
    // Byte store of 0xDD, then signed byte load of it.
    req(1'b1, 2'b00, 1'b0, 32'h5, 32'hAABBCCDD, 1'b0, 32'h0000F001, 1, 1'b0);
    req(1'b0, 2'b00, 1'b1, 32'h5, 32'h0,        1'b0, 32'hFFFFFFDD, 1, 1'b0);
    // Aborted requests: misaligned word, illegal size, misaligned half.
    req(1'b0, 2'b10, 1'b0, 32'h6, 32'h0,        1'b1, 32'hFFFFFFDD, 0, 1'b0);
    req(1'b0, 2'b11, 1'b0, 32'h0, 32'h0,        1'b1, 32'hFFFFFFDD, 0, 1'b0);
    req(1'b1, 2'b01, 1'b0, 32'h3, 32'h1234,     1'b1, 32'hFFFFFFDD, 0, 1'b0);
    // Unsigned byte load with a Start pulse on the Done cycle.
    req(1'b0, 2'b00, 1'b0, 32'h5, 32'h0,        1'b0, 32'h000000DD, 1, 1'b1);

    // Word load interrupted by reset at its third byte; second Start ignored.
    @(negedge CLK);
    RW = 1'b0; Size = 2'b10; Signed = 1'b0; Addr = 32'h8; Start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      acc_t e;
      e.rw = 1'b0; e.addr = 32'h8 + 32'(k); e.wd = 8'h00;
      acc_q.push_back(e);
    end
    @(negedge CLK);
    RW = 1'b1; Size = 2'b00; Addr = 32'h20; DataIn = 32'h77;
    @(negedge CLK);
    Start = 1'b0;
    @(negedge CLK);
    #1 Reset = 1'b0;
    #1;
    chk("midrst_busy", 32'(Busy), 32'd0);
    chk("midrst_memen", 32'(MemEn), 32'd0);
    chk("midrst_done", 32'(Done), 32'd0);
    chk("midrst_dataout", DataOut, 32'd0);
    chk("midrst_pending_access", 32'(acc_q.size()), 32'd0);
    exp_dout = 32'd0;
    repeat (2) begin
      @(negedge CLK);
      chk("midrst_no_done", 32'(Done), 32'd0);
    end
    #1 Reset = 1'b1;
    req(1'b0, 2'b00, 1'b0, 32'h3, 32'h0,        1'b0, 32'h00000001, 1, 1'b0);
    chk("mem_written_word", {mem[8], mem[9], mem[10], mem[11]}, 32'h11223344);

    repeat (3) @(negedge CLK);
    chk("acc_queue_empty", 32'(acc_q.size()), 32'd0);
    chk("rsp_queue_empty", 32'(rsp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Initiator side of the CPU data-memory interface. Accepts one load/store request from the CPU core and performs it as a sequence of single-byte accesses on a byte-wide data-memory port.
- Supports byte, halfword and word transfers with big-endian byte order: the byte at Addr is the most significant.
- Loads are zero- or sign-extended. Requests are checked for alignment before any memory access is made.

Parameters:
- MEM_BYTES, 512, size of the attached byte memory; used only by the optional bounds check.

Ports:
- CLK  input  1  clock, rising edge.
- Reset  input  1  asynchronous, active-low reset.
- Start  input  1  request strobe; sampled only in IDLE.
- RW  input  1  0 = load, 1 = store.
- Size  input  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
- Signed  input  1  1 = sign-extend load result.
- Addr  input  32  byte address.
- DataIn  input  32  store data; only the low 8/16 bits are used for byte/half.
- Busy  output  1  high from the cycle after an accepted Start until Done.
- Done  output  1  one-cycle completion pulse.
- DataOut  output  32  load result; held until the next load completes.
- AlignErr  output  1  valid with Done; request aborted.
- MemEn  output  1  byte-port access enable.
- MemRW  output  1  byte-port write enable.
- MemAddr  output  32  byte-port address.
- MemWData  output  8  byte-port write data.
- MemRData  input  8  byte-port read data; combinational, valid in the same cycle as MemAddr.

Behaviour:
- Reset (Reset=0, asynchronous): state IDLE; Busy, Done, AlignErr, MemEn, MemRW = 0; DataOut, MemAddr, MemWData = 0; byte counter = 0.
- Reset asserted mid-transfer abandons the transfer immediately. No Done is produced. Bytes already written stay written.
- FSM states: IDLE, ACCESS, FINISH.
- IDLE, Start=1:
  - Latch RW, Size, Signed, Addr, DataIn.
  - Byte count N = 1/2/4 for Size 00/01/10.
  - Illegal cases: Size=11, half with Addr[0]=1, or word with Addr[1:0]!=0. These go to FINISH with AlignErr set and no memory access.
  - Otherwise go to ACCESS with counter = 0.
- ACCESS, per cycle with counter k:
  - MemEn=1, MemRW=RW, MemAddr=Addr+k.
  - Store: MemWData = byte (N-1-k) of the latched data, where byte 0 is the LSB. The most significant used byte goes out first.
  - Load: shift MemRData into an internal accumulator, MSB first.
  - Counter increments each cycle. After k=N-1, go to FINISH.
- ACCESS timing: exactly N consecutive MemEn cycles, no gaps. MemEn is 0 in every other state.
- FINISH:
  - Done=1 for one cycle.
  - For a successful load, DataOut is updated in this same cycle: the accumulator's low 8N bits, zero- or sign-extended per Signed.
  - AlignErr=1 only when the request was aborted. DataOut is unchanged on error and on stores.
  - Next state is IDLE.
- Busy: 1 in ACCESS and FINISH, 0 in IDLE.
- Latency from the Start cycle to Done: N+1 cycles (byte/half/word = 2/3/5); 1 cycle for an aborted request.
- Start while Busy=1 is ignored. Start in the same cycle as Done (in FINISH) is also ignored. A new request is accepted only in IDLE.
- Address arithmetic: Addr+k is 32-bit and wraps modulo 2^32.
- Signed is ignored for stores and for word loads.

Optional Feature:
- Macro: MAU_BOUNDS_CHECK_EN.
- When defined:
  - Any request with Addr+N-1 >= MEM_BYTES is treated like a misaligned request.
  - It goes to FINISH with no memory access and raises an extra output BoundErr (1 bit), valid with Done; AlignErr stays 0 unless the request is also misaligned.
  - BoundErr resets to 0.
- When undefined: there is no BoundErr port, no range comparison, and out-of-range addresses are driven to the memory port unchanged.

Test Plan:
- Word store: Addr=0x8, DataIn=0x11223344. Expect MemAddr 8,9,10,11 with MemWData 0x11,0x22,0x33,0x44 on consecutive cycles. Done 5 cycles after Start; AlignErr=0.
- Word load: memory[8..11]=0x11,0x22,0x33,0x44. Expect DataOut=0x11223344 on the Done cycle and held afterwards.
- Signed half load: Addr=0x2, bytes 0xF0,0x01. Expect DataOut=0xFFFFF001 when Signed=1 and 0x0000F001 when Signed=0. Done 3 cycles after Start.
- Byte store: Addr=0x5, DataIn=0xAABBCCDD. Expect a single MemEn cycle, MemAddr=5, MemWData=0xDD.
- Misaligned word load: Addr=0x6, then Size=11. Expect Done and AlignErr one cycle after Start, MemEn never asserted, DataOut unchanged.
- Start pulsed during a word access, then Reset pulsed low at the third MemEn cycle. Expect the second Start ignored; after reset, Busy=0, MemEn=0, no Done pulse. A new byte load then completes normally in 2 cycles.
